// File: rtl/clarvi_sliced_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : clarvi_sliced_alu_if
// Purpose  : Request/response bundle between issue logic and the sliced ALU.
// Revision : 1.0
// ============================================================================
interface clarvi_sliced_alu_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic            word;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, op, word, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, word, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface
`default_nettype wire

// File: rtl/clarvi_sliced_alu.sv
`default_nettype none
// ============================================================================
// Module   : clarvi_sliced_alu
// Purpose  : Multi-cycle RV64I ALU processing one SLICE-wide slice per cycle.
//            Define CLARVI_SLICED_ALU_EARLY_EXIT_EN to let SLT/SLTU finish on
//            the first differing slice.
// Revision : 1.0
// ============================================================================
module clarvi_sliced_alu #(
  parameter int XLEN  = 64,
  parameter int SLICE = 32
) (
  input wire                 clock,
  input wire                 reset_n,
  input wire                 flush,
  clarvi_sliced_alu_if.slave bus
);
  localparam int NS  = XLEN / SLICE;
  localparam int NW  = (SLICE >= 32) ? 1 : (32 / SLICE);
  localparam int IW  = (NS > 1) ? $clog2(NS) : 1;
  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic            word_q, word_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            eq_q, eq_d;
  logic            lt_q, lt_d;

  logic             is_cmp, is_logic, is_last, finish, cin;
  logic             slice_eq, slice_lt;
  logic [IW-1:0]    idx;
  logic [SLICE-1:0] a_s, b_s, b_x, slice_val;
  logic [SLICE:0]   sum;
  logic [SHW-1:0]   sh_full;
  logic [4:0]       sh_w;
  logic [31:0]      sll_w, srl_w, sra_w;
  logic [XLEN-1:0]  sra_f, shf, res_new;

  always_comb begin
    is_cmp   = !word_q && ((op_q == OP_SLT) || (op_q == OP_SLTU));
    is_logic = !word_q && ((op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_XOR));
    is_last  = (cnt_q == (word_q ? IW'(NW - 1) : IW'(NS - 1)));
    // Compares walk MSB-first so the first differing slice decides the outcome.
    idx      = is_cmp ? (IW'(NS - 1) - cnt_q) : cnt_q;
    a_s      = a_q[int'(idx)*SLICE +: SLICE];
    b_s      = b_q[int'(idx)*SLICE +: SLICE];

    b_x = (op_q == OP_SUB) ? ~b_s : b_s;
    cin = (cnt_q == '0) ? (op_q == OP_SUB) : carry_q;
    sum = {1'b0, a_s} + {1'b0, b_x} + (SLICE + 1)'(cin);

    slice_eq = (a_s == b_s);
    if ((op_q == OP_SLT) && (idx == IW'(NS - 1))) begin
      slice_lt = ($signed(a_s) < $signed(b_s));
    end else begin
      slice_lt = (a_s < b_s);
    end

    sh_full = b_q[SHW-1:0];
    sh_w    = b_q[4:0];
    sll_w   = a_q[31:0] << sh_w;
    srl_w   = a_q[31:0] >> sh_w;
    sra_w   = $signed(a_q[31:0]) >>> sh_w;
    sra_f   = $signed(a_q) >>> sh_full;
    case (op_q)
      OP_SLL:  shf = word_q ? XLEN'(sll_w) : (a_q << sh_full);
      OP_SRL:  shf = word_q ? XLEN'(srl_w) : (a_q >> sh_full);
      OP_SRA:  shf = word_q ? XLEN'(sra_w) : sra_f;
      default: shf = '0;
    endcase

    case (op_q)
      OP_ADD, OP_SUB:         slice_val = sum[SLICE-1:0];
      OP_AND:                 slice_val = is_logic ? (a_s & b_s) : '0;
      OP_OR:                  slice_val = is_logic ? (a_s | b_s) : '0;
      OP_XOR:                 slice_val = is_logic ? (a_s ^ b_s) : '0;
      OP_SLL, OP_SRL, OP_SRA: slice_val = shf[int'(idx)*SLICE +: SLICE];
      default:                slice_val = '0;
    endcase

    res_new = result_q;
    res_new[int'(idx)*SLICE +: SLICE] = slice_val;

`ifdef CLARVI_SLICED_ALU_EARLY_EXIT_EN
    finish = is_last || (is_cmp && eq_q && !slice_eq);
`else
    finish = is_last;
`endif
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    word_d   = word_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && !flush) begin
          op_d    = bus.op;
          word_d  = bus.word;
          a_d     = bus.a;
          b_d     = bus.b;
          cnt_d   = '0;
          carry_d = 1'b0;
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d   = cnt_q + 1'b1;
        carry_d = sum[SLICE];
        if (is_cmp) begin
          if (eq_q) begin
            lt_d = slice_lt;
            eq_d = slice_eq;
          end
        end else begin
          result_d = res_new;
        end
        if (finish) begin
          state_d = S_DONE;
          if (is_cmp) begin
            result_d = XLEN'(lt_d);
          end else if (word_q) begin
            result_d = XLEN'($signed(res_new[31:0]));
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      word_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      eq_q     <= 1'b1;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      word_q   <= word_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.result    = result_q;
endmodule
`default_nettype wire

// File: tb/tb_clarvi_sliced_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_clarvi_sliced_alu
// Purpose  : Scoreboard bench for clarvi_sliced_alu at XLEN=64, SLICE=16.
// Revision : 1.0
// ============================================================================
module tb_clarvi_sliced_alu;
  localparam int XLEN  = 64;
  localparam int SLICE = 16;
  localparam int NS    = XLEN / SLICE;
  localparam int NW    = 32 / SLICE;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  logic clock;
  logic reset_n;
  logic flush;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  clarvi_sliced_alu_if #(.XLEN(XLEN)) bus ();

  clarvi_sliced_alu #(.XLEN(XLEN), .SLICE(SLICE)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_alu(input logic [3:0] o, input logic w,
                                          input logic [63:0] x, input logic [63:0] y);
    logic [63:0] r;
    logic [31:0] t;
    r = '0;
    t = '0;
    if (w) begin
      case (o)
        4'd0:    t = x[31:0] + y[31:0];
        4'd1:    t = x[31:0] - y[31:0];
        4'd7:    t = x[31:0] << y[4:0];
        4'd8:    t = x[31:0] >> y[4:0];
        4'd9:    t = $signed(x[31:0]) >>> y[4:0];
        default: t = '0;
      endcase
      r = {{32{t[31]}}, t};
    end else begin
      case (o)
        4'd0:    r = x + y;
        4'd1:    r = x - y;
        4'd2:    r = x & y;
        4'd3:    r = x | y;
        4'd4:    r = x ^ y;
        4'd5:    r = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
        4'd6:    r = (x < y) ? 64'd1 : 64'd0;
        4'd7:    r = x << y[5:0];
        4'd8:    r = x >> y[5:0];
        4'd9:    r = $signed(x) >>> y[5:0];
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  function automatic int ref_lat(input logic [3:0] o, input logic w,
                                 input logic [63:0] x, input logic [63:0] y);
    int  lat;
    bit  found;
    lat   = w ? NW : NS;
    found = 1'b0;
`ifdef CLARVI_SLICED_ALU_EARLY_EXIT_EN
    if (!w && (o == 4'd5 || o == 4'd6)) begin
      for (int i = NS - 1; i >= 0; i--) begin
        if (!found && (x[i*SLICE +: SLICE] != y[i*SLICE +: SLICE])) begin
          lat   = NS - i;
          found = 1'b1;
        end
      end
    end
`else
    if (o == 4'hF) found = 1'b1;
`endif
    return lat;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after accept.
  task automatic send(input logic [3:0] o, input logic w, input logic [63:0] x,
                      input logic [63:0] y, input bit push);
    exp_t e;
    check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.word     = w;
    bus.a        = x;
    bus.b        = y;
    if (push) begin
      e.res = ref_alu(o, w, x, y);
      e.lat = ref_lat(o, w, x, y);
      sb.push_back(e);
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.a        = {$urandom, $urandom};
    bus.b        = {$urandom, $urandom};
    bus.op       = 4'($urandom_range(0, 15));
    bus.word     = 1'($urandom_range(0, 1));
  endtask

  task automatic collect(input int hold);
    int   lat;
    exp_t e;
    lat = 0;
    while (!bus.out_valid && lat < 64) begin
      @(negedge clock);
      lat++;
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check("latency", 64'(lat), 64'(e.lat));
      check("result", bus.result, e.res);
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        check("hold_result", bus.result, e.res);
        check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);
    check("idle_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  task automatic run_op(input logic [3:0] o, input logic w, input logic [63:0] x,
                        input logic [63:0] y);
    send(o, w, x, y, 1'b1);
    collect(0);
  endtask

  initial begin
    bit saw_valid;
    n_checks      = 0;
    n_errors      = 0;
    reset_n       = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = '0;
    bus.word      = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (2) @(negedge clock);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_result", bus.result, 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    run_op(4'd0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1);
    run_op(4'd1, 1'b0, 64'd0, 64'd1);
    run_op(4'd1, 1'b1, 64'd0, 64'd1);
    run_op(4'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    run_op(4'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    run_op(4'd5, 1'b0, 64'd5, 64'd7);
    run_op(4'd6, 1'b0, 64'h8000_0000_0000_0000, 64'd1);
    run_op(4'd5, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
    run_op(4'd9, 1'b0, 64'h8000_0000_0000_0000, 64'd4);
    run_op(4'd8, 1'b1, 64'h0000_0000_8000_0000, 64'd31);
    run_op(4'd7, 1'b1, 64'd1, 64'd31);
    run_op(4'd9, 1'b1, 64'hFFFF_FFFF_8000_00F0, 64'd36);
    run_op(4'd2, 1'b0, 64'hF0F0_1234_FFFF_0000, 64'h0FF0_FFFF_00FF_FF00);
    run_op(4'd4, 1'b0, 64'hAAAA_5555_AAAA_5555, 64'hFFFF_0000_0F0F_F0F0);
    run_op(4'd12, 1'b0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
    run_op(4'd3, 1'b1, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
    for (int i = 0; i < 10; i++) begin
      run_op(4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
             {$urandom, $urandom}, {$urandom, $urandom});
    end

    send(4'd0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    collect(5);
    run_op(4'd1, 1'b0, 64'd100, 64'd58);

    // Abort during the first RUN cycle.
    send(4'd0, 1'b0, 64'd3, 64'd4, 1'b0);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_busy", 64'(bus.busy), 64'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      saw_valid = saw_valid | bus.out_valid;
    end
    check("flush_no_out_valid", 64'(saw_valid), 64'd0);

    // Request coinciding with flush must be dropped.
    bus.in_valid = 1'b1;
    bus.op       = 4'd0;
    bus.word     = 1'b0;
    flush        = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    check("flush_accept_busy", 64'(bus.busy), 64'd0);
    check("flush_accept_in_ready", 64'(bus.in_ready), 64'd1);

    run_op(4'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);

    // Asynchronous reset in the middle of an operation.
    send(4'd0, 1'b0, 64'd9, 64'd9, 1'b0);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_result", bus.result, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    run_op(4'd1, 1'b1, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/clarvi_sliced_alu.md
Name: clarvi_sliced_alu

Overview:
- Multi-cycle integer ALU that executes XLEN-wide RV64I ALU ops one SLICE-wide slice per cycle, with carry and compare state held between slices.
- Generalises the two-part 64-on-32 ALU to any power-of-two slice count. Adds valid/ready handshakes, an internal sequencer and a flush input.
- Sits in the execute stage. The issue logic presents fully latched operands once and collects one XLEN result.

Parameters:
- XLEN, 64, operand/result width; must be 32 or 64.
- SLICE, 32, datapath slice width; one of 8, 16, 32, 64; must divide XLEN. NS = XLEN/SLICE; NW = max(1, 32/SLICE).

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort; drops any in-flight op.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA; 10-15 reserved.
- word  in  1  RV64 W-variant (ADD/SUB/SLL/SRL/SRA only).
- a, b  in  XLEN  operands (b already muxed with immediate).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- result  out  XLEN  result, stable while out_valid.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, slice counter=0, carry=0, eq=1, lt=0.
- FSM states:
  - IDLE: on in_valid&&in_ready, latch op, word, a, b; go to RUN.
  - RUN: process one slice per cycle.
  - DONE: hold result with out_valid=1; on out_ready go to IDLE.
- Accept to out_valid latency: NS cycles (NW when word=1). Back-to-back: next accept is 1 cycle after the out handshake (IDLE is visited once).
- ADD/SUB/AND/OR/XOR: slices processed LSB to MSB.
  - SUB uses ~b and carry-in 1 on slice 0; carry-out is registered into the next slice.
  - Carry out of the top slice is discarded (mod 2^XLEN wrap).
- SLT/SLTU: slices processed MSB to LSB, with flags eq and lt.
  - Top slice compares signed for SLT, unsigned for SLTU; all lower slices compare unsigned.
  - Slice update: if eq, lt := slice_lt and eq := slice_eq.
  - Result = zero-extended lt.
- Shifts: shamt = b[log2(XLEN)-1:0], or b[4:0] when word=1.
  - Result slice i = slice i of the full-width shift of the latched a. SRA fills with a[XLEN-1].
  - Processed LSB to MSB.
- word=1:
  - Only the low 32 bits are computed, over NW slices.
  - SRL/SRA operate on a[31:0]; SRA fills with a[31].
  - Final result is bits[31:0] sign-extended from bit 31.
  - SLICE=64: one slice, same extension.
- Reserved op, or word=1 with AND/OR/XOR/SLT/SLTU: completes normally with result=0.
- flush: in any state, next cycle is IDLE with out_valid=0. Accumulated result is not cleared. A same-cycle in_valid is not accepted.
- Asynchronous reset mid-op: immediately returns all registers to reset values; the op is lost.
- a and b are sampled only at accept; later input changes have no effect.

Optional Feature:
- Macro CLARVI_SLICED_ALU_EARLY_EXIT_EN.
- Defined: SLT/SLTU go to DONE in the cycle after the first slice with slice_eq=0, so latency is between 1 and NS. All other ops are unchanged.
- Undefined: SLT/SLTU always take NS cycles; the extra slices leave lt unchanged.

Test Plan:
- XLEN=64, SLICE=32, ADD a=0x0000_0000_FFFF_FFFF b=1 -> out_valid 2 cycles after accept; result=0x0000_0001_0000_0000.
- SLICE=16, SUB a=0 b=1 -> result=0xFFFF_FFFF_FFFF_FFFF after 4 cycles; word=1 SUB same operands -> 0xFFFF_FFFF_FFFF_FFFF after 2 cycles.
- SLT a=0xFFFF_FFFF_FFFF_FFFF b=1 -> result 1; SLTU with the same operands -> 0. With EARLY_EXIT_EN both take 1 cycle; without it, 2 cycles.
- SRA a=0x8000_0000_0000_0000 b=4 -> 0xF800_0000_0000_0000; word=1 SRL a=0x0000_0000_8000_0000 b=31 -> 0x1; word=1 SLL a=1 b=31 -> 0xFFFF_FFFF_8000_0000.
- Hold out_ready=0 for 5 cycles -> result stable, in_ready=0; then out_ready=1 -> IDLE next cycle, new accept the following cycle.
- Assert flush in the 1st RUN cycle -> IDLE, no out_valid. Deassert reset_n mid-RUN -> in_ready=1, out_valid=0, result=0 immediately.
